// File: rtl/fifo_fwft_if.sv
// rtl/fifo_fwft_if.sv - valid/ready write and read channels of fifo_fwft
interface fifo_fwft_if #(
   parameter int WIDTH = 8
);
   logic             wr_valid;
   logic [WIDTH-1:0] wr_data;
   logic             wr_ready;
   logic             rd_valid;
   logic [WIDTH-1:0] rd_data;
   logic             rd_ready;

   modport master (
      output wr_valid, wr_data, rd_ready,
      input  wr_ready, rd_valid, rd_data
   );

   modport slave (
      input  wr_valid, wr_data, rd_ready,
      output wr_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/fifo_fwft.sv
// rtl/fifo_fwft.sv - first-word-fall-through FIFO on a registered-read RAM
module fifo_fwft #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 512,
   parameter int AF_THRESH = DEPTH - 10,
   parameter int AE_THRESH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   fifo_fwft_if.slave           bus,
   output logic [$clog2(DEPTH):0] level,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 overflow,
   input  logic                 clear_errors
);
   localparam int DB = $clog2(DEPTH);
   localparam int LW = DB + 1;
   localparam logic [LW-1:0] ONE_L   = LW'(1);
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
   localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);
   localparam logic [DB-1:0] PTR_ONE = DB'(1);

   // State describes the output stage; pref_valid tracks the RAM read register.
   typedef enum logic [1:0] {S_EMPTY, S_PREF, S_VALID} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] ram_q;
   logic [WIDTH-1:0] rd_data_q;
   logic [DB-1:0]    wr_ptr, rd_ptr;
   logic [LW-1:0]    ram_count, ram_count_next, level_next;
   logic             pref_valid, pref_valid_next;
   logic             wr_ready_q;
   logic             push, pop, load_out, issue_rd;

   assign bus.wr_ready = wr_ready_q;
   assign bus.rd_valid = (state == S_VALID);
   assign bus.rd_data  = rd_data_q;

   always_comb begin
      push     = bus.wr_valid & wr_ready_q & ~flush;
      pop      = bus.rd_valid & bus.rd_ready & ~flush;
      load_out = pref_valid & (~bus.rd_valid | pop) & ~flush;
      issue_rd = (ram_count != '0) & (~pref_valid | load_out) & ~flush;

      level_next = level;
      case ({push, pop})
         2'b10:   level_next = level + ONE_L;
         2'b01:   level_next = level - ONE_L;
         default: level_next = level;
      endcase

      ram_count_next = ram_count;
      case ({push, issue_rd})
         2'b10:   ram_count_next = ram_count + ONE_L;
         2'b01:   ram_count_next = ram_count - ONE_L;
         default: ram_count_next = ram_count;
      endcase
   end

   always_comb begin
      state_next      = state;
      pref_valid_next = pref_valid;
      if (issue_rd)
         pref_valid_next = 1'b1;
      else if (load_out)
         pref_valid_next = 1'b0;

      case (state)
         S_EMPTY: if (issue_rd) state_next = S_PREF;
         S_PREF:  if (load_out) state_next = S_VALID;
         S_VALID: if (pop && !load_out)
                     state_next = pref_valid_next ? S_PREF : S_EMPTY;
         default: state_next = S_EMPTY;
      endcase
   end

   // Plain RAM process without reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= bus.wr_data;
      if (issue_rd)
         ram_q <= mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_EMPTY;
         pref_valid   <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         ram_count    <= '0;
         level        <= '0;
         rd_data_q    <= '0;
         wr_ready_q   <= 1'b0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else if (flush) begin
         state        <= S_EMPTY;
         pref_valid   <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         ram_count    <= '0;
         level        <= '0;
         wr_ready_q   <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         state        <= state_next;
         pref_valid   <= pref_valid_next;
         ram_count    <= ram_count_next;
         level        <= level_next;
         wr_ready_q   <= (level_next < DEPTH_L);
         almost_full  <= (level_next >= AF_L);
         almost_empty <= (level_next <= AE_L);
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (issue_rd)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (load_out)
            rd_data_q <= ram_q;
      end
   end

   // A fresh overflow event beats a coincident clear.
   always_ff @(posedge clk) begin
      if (reset)
         overflow <= 1'b0;
      else if (bus.wr_valid && !wr_ready_q)
         overflow <= 1'b1;
      else if (clear_errors)
         overflow <= 1'b0;
   end
endmodule

// File: tb/tb_fifo_fwft.sv
// tb/tb_fifo_fwft.sv - directed and scoreboarded checks of fifo_fwft (8x8)
module tb_fifo_fwft;
   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic       clear_errors;
   logic [3:0] level;
   logic       almost_full, almost_empty, overflow;

   int n_tests = 0;
   int n_fail  = 0;

   fifo_fwft_if #(.WIDTH(8)) bus ();

   fifo_fwft #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .bus          (bus),
      .level        (level),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .clear_errors (clear_errors)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag, input int first, input int count);
      int n;
      n = 0;
      bus.rd_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (bus.rd_valid) begin
            check(tag, 32'(bus.rd_data), 32'(first + n));
            n++;
         end
         step();
      end
      bus.rd_ready = 1'b0;
      check({tag, "_count"}, 32'(n), 32'(count));
   endtask

   int     wi, ri, mlev, npush;
   logic   ov_m, pushed, do_push, do_pop;
   logic [7:0] sb[$];

   initial begin
      reset = 1'b1; flush = 1'b0; clear_errors = 1'b0;
      bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
      step(); step();
      check("rst_level", 32'(level), 0);
      check("rst_rd_valid", 32'(bus.rd_valid), 0);
      check("rst_rd_data", 32'(bus.rd_data), 0);
      check("rst_wr_ready", 32'(bus.wr_ready), 0);
      check("rst_af", 32'(almost_full), 0);
      check("rst_ae", 32'(almost_empty), 1);
      check("rst_ovf", 32'(overflow), 0);
      reset = 1'b0;
      step();
      check("rst_wr_ready_after", 32'(bus.wr_ready), 1);

      // 1: single word latency
      bus.wr_valid = 1'b1; bus.wr_data = 8'hA5;
      step();
      bus.wr_valid = 1'b0;
      check("t1_valid_e0", 32'(bus.rd_valid), 0);
      check("t1_level", 32'(level), 1);
      step();
      check("t1_valid_e1", 32'(bus.rd_valid), 0);
      step();
      check("t1_valid_e2", 32'(bus.rd_valid), 1);
      check("t1_data", 32'(bus.rd_data), 32'h A5);
      check("t1_ae", 32'(almost_empty), 1);
      bus.rd_ready = 1'b1;
      step();
      bus.rd_ready = 1'b0;
      check("t1_level_pop", 32'(level), 0);
      check("t1_valid_pop", 32'(bus.rd_valid), 0);

      // 2: fill, flags, overflow, drain
      for (int i = 0; i < 8; i++) begin
         bus.wr_valid = 1'b1; bus.wr_data = 8'(i);
         step();
         check("t2_level", 32'(level), 32'(i + 1));
         check("t2_af", 32'(almost_full), 32'((i + 1) >= 6));
         check("t2_wr_ready", 32'(bus.wr_ready), 32'((i + 1) < 8));
      end
      bus.wr_data = 8'hFF;
      step();
      bus.wr_valid = 1'b0;
      check("t2_ovf", 32'(overflow), 1);
      check("t2_level_full", 32'(level), 8);
      step(); step();
      check("t2_hold_valid", 32'(bus.rd_valid), 1);
      check("t2_hold_data", 32'(bus.rd_data), 0);
      drain("t2_drain", 0, 8);
      clear_errors = 1'b1;
      step();
      clear_errors = 1'b0;
      check("t2_ovf_clear", 32'(overflow), 0);

      // 3: streaming 100 words
      wi = 0; ri = 0;
      bus.rd_ready = 1'b1;
      for (int c = 0; c < 115; c++) begin
         if (c < 3) check("t3_fill", 32'(bus.rd_valid), 0);
         if (c >= 3 && c <= 100) check("t3_level", 32'(level), 3);
         if (c >= 3 && c <= 102) check("t3_valid", 32'(bus.rd_valid), 1);
         if (bus.rd_valid) begin
            check("t3_data", 32'(bus.rd_data), 32'(ri));
            ri++;
         end
         bus.wr_valid = (wi < 100);
         bus.wr_data  = 8'(wi);
         pushed = bus.wr_valid && bus.wr_ready;
         step();
         if (pushed) wi++;
      end
      bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
      check("t3_count", 32'(ri), 100);

      // 4: full with simultaneous push and pop
      for (int i = 0; i < 8; i++) begin
         bus.wr_valid = 1'b1; bus.wr_data = 8'(8'h10 + i);
         step();
      end
      bus.wr_valid = 1'b0;
      step(); step();
      check("t4_level_full", 32'(level), 8);
      check("t4_ovf_before", 32'(overflow), 0);
      bus.wr_valid = 1'b1; bus.rd_ready = 1'b1; bus.wr_data = 8'h55;
      step();
      bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
      check("t4_level", 32'(level), 7);
      check("t4_ovf", 32'(overflow), 1);
      check("t4_wr_ready", 32'(bus.wr_ready), 1);
      drain("t4_drain", 8'h11, 7);

      // 5: flush
      for (int i = 0; i < 5; i++) begin
         bus.wr_valid = 1'b1; bus.wr_data = 8'(8'h20 + i);
         step();
      end
      bus.wr_valid = 1'b0;
      step(); step();
      check("t5_level_pre", 32'(level), 5);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("t5_level", 32'(level), 0);
      check("t5_valid", 32'(bus.rd_valid), 0);
      check("t5_ovf", 32'(overflow), 1);
      check("t5_wr_ready", 32'(bus.wr_ready), 1);
      check("t5_ae", 32'(almost_empty), 1);
      bus.wr_valid = 1'b1; bus.wr_data = 8'h3C;
      step();
      bus.wr_valid = 1'b0;
      check("t5_valid_e0", 32'(bus.rd_valid), 0);
      step();
      check("t5_valid_e1", 32'(bus.rd_valid), 0);
      step();
      check("t5_valid_e2", 32'(bus.rd_valid), 1);
      check("t5_data", 32'(bus.rd_data), 32'h3C);
      bus.rd_ready = 1'b1;
      step();
      bus.rd_ready = 1'b0;
      clear_errors = 1'b1;
      step();
      clear_errors = 1'b0;
      check("t5_ovf_clear", 32'(overflow), 0);
      check("t5_empty", 32'(level), 0);

      // 6: random traffic against a scoreboard
      mlev = 0; ov_m = 1'b0; npush = 0;
      for (int c = 0; c < 3000 && (npush < 24 || sb.size() > 0); c++) begin
         bus.wr_valid = (npush < 24) && ($urandom_range(0, 99) < 70);
         bus.wr_data  = 8'($urandom_range(0, 255));
         bus.rd_ready = 1'($urandom_range(0, 1));
         clear_errors = ($urandom_range(0, 9) == 0);
         check("t6_wr_ready", 32'(bus.wr_ready), 32'(mlev < 8));
         do_push = bus.wr_valid && (mlev < 8);
         do_pop  = bus.rd_valid && bus.rd_ready;
         if (do_pop) begin
            check("t6_pop_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) check("t6_data", 32'(bus.rd_data), 32'(sb.pop_front()));
         end
         if (do_push) begin
            sb.push_back(bus.wr_data);
            npush++;
         end
         if (bus.wr_valid && !(mlev < 8)) ov_m = 1'b1;
         else if (clear_errors) ov_m = 1'b0;
         mlev = mlev + int'(do_push) - int'(do_pop);
         step();
         check("t6_level", 32'(level), 32'(mlev));
         check("t6_ovf", 32'(overflow), 32'(ov_m));
         check("t6_af", 32'(almost_full), 32'(mlev >= 6));
         check("t6_ae", 32'(almost_empty), 32'(mlev <= 1));
      end
      bus.wr_valid = 1'b0; bus.rd_ready = 1'b0; clear_errors = 1'b0;
      check("t6_pushed", 32'(npush), 24);
      check("t6_sb_left", 32'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
